// File: rtl/ap_host_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ap_host_ctrl : loads operand columns A/B into an associative processor,      |
// | runs its OR pass and streams column C back.  Rev 1.0                         |
// +----------------------------------------------------------------------------+
module ap_host_ctrl #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      n_cells,
  input  logic                 opnd_valid,
  output logic                 opnd_ready,
  input  logic [WORD_SIZE-1:0] opnd_a,
  input  logic [WORD_SIZE-1:0] opnd_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] res_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ap_rst,
  output logic                 ap_mode,
  output logic [2:0]           ap_cmd,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_sel_internal_col,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_wdata,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  input  logic [WORD_SIZE-1:0] ap_rdata,
  input  logic                 ap_irq
);

  localparam int              c_CNT_W     = ADDR_W + 1;
  localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CELLS     = c_CNT_W'(CELL_QUANT);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = (RD_LAT > 1) ? c_CNT_W'(RD_LAT - 2) : '0;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLEAR    = 4'd1,
    S_LOAD_A   = 4'd2,
    S_LOAD_B   = 4'd3,
    S_RUN      = 4'd4,
    S_RD_ISSUE = 4'd5,
    S_RD_WAIT  = 4'd6,
    S_RD_OUT   = 4'd7,
    S_FIN      = 4'd8
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     r_n;
  logic [c_CNT_W-1:0]     r_timer;
  logic [WORD_SIZE-1:0]   r_b;
  logic [WORD_SIZE-1:0]   r_res;
  logic                   r_err;
  logic                   r_err_done;
  logic                   w_n_ok;
  logic                   w_last;

  assign w_n_ok = (n_cells != '0) && (n_cells <= c_CELLS);
  assign w_last = (r_cnt == (r_n - c_ONE));

  assign res_data            = r_res;
  assign err                 = r_err;
  assign ap_cmd              = 3'b000;
  assign ap_sel_internal_col = 1'b0;

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    opnd_ready  = 1'b0;
    res_valid   = 1'b0;
    ap_rst      = 1'b0;
    ap_mode     = 1'b0;
    ap_sel_col  = 2'd0;
    ap_addr     = '0;
    ap_wdata    = '0;
    ap_write_en = 1'b0;
    ap_read_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        done = r_err_done;
        if (start && w_n_ok) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        ap_rst = 1'b1;
        w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        opnd_ready = 1'b1;
        // Column A is written in the handshake cycle itself; B follows from r_b.
        if (opnd_valid) begin
          ap_write_en = 1'b1;
          ap_addr     = r_cnt[ADDR_W-1:0];
          ap_wdata    = opnd_a;
          w_next      = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        ap_write_en = 1'b1;
        ap_sel_col  = 2'd1;
        ap_addr     = r_cnt[ADDR_W-1:0];
        ap_wdata    = r_b;
        w_next      = w_last ? S_RUN : S_LOAD_A;
      end
      S_RUN: begin
        ap_mode = 1'b1;
        if (ap_irq)                       w_next = S_RD_ISSUE;
        else if (r_timer == c_TMO_LAST)   w_next = S_FIN;
      end
      S_RD_ISSUE: begin
        ap_read_en = 1'b1;
        ap_sel_col = 2'd2;
        ap_addr    = r_cnt[ADDR_W-1:0];
        w_next     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_timer == c_WAIT_LAST) w_next = S_RD_OUT;
      end
      S_RD_OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = w_last ? S_FIN : S_RD_ISSUE;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_n        <= '0;
      r_timer    <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_err      <= 1'b0;
      r_err_done <= 1'b0;
    end else begin
      r_err_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_n_ok) begin
              r_n   <= n_cells;
              r_err <= 1'b0;
            end else begin
              r_err      <= 1'b1;
              r_err_done <= 1'b1;
            end
          end
        end
        S_CLEAR:  r_cnt <= '0;
        S_LOAD_A: if (opnd_valid) r_b <= opnd_b;
        S_LOAD_B: begin
          r_timer <= '0;
          r_cnt   <= w_last ? '0 : r_cnt + c_ONE;
        end
        S_RUN: begin
          r_timer <= r_timer + c_ONE;
          if (!ap_irq && (r_timer == c_TMO_LAST)) r_err <= 1'b1;
        end
        S_RD_ISSUE: r_timer <= '0;
        S_RD_WAIT: begin
          r_timer <= r_timer + c_ONE;
          if (r_timer == c_WAIT_LAST) r_res <= ap_rdata;
        end
        S_RD_OUT: if (res_ready && !w_last) r_cnt <= r_cnt + c_ONE;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ap_host_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ap_host_ctrl : directed bench for ap_host_ctrl with a small AP model.     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_ap_host_ctrl;

  localparam int WS = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   n_cells;
  logic          opnd_valid;
  logic          opnd_ready;
  logic [WS-1:0] opnd_a;
  logic [WS-1:0] opnd_b;
  logic          res_valid;
  logic          res_ready;
  logic [WS-1:0] res_data;
  logic          busy;
  logic          done;
  logic          err;
  logic          ap_rst;
  logic          ap_mode;
  logic [2:0]    ap_cmd;
  logic [1:0]    ap_sel_col;
  logic          ap_sel_internal_col;
  logic [AW-1:0] ap_addr;
  logic [WS-1:0] ap_wdata;
  logic          ap_write_en;
  logic          ap_read_en;
  logic [WS-1:0] ap_rdata;
  logic          ap_irq;

  always #5 clk = ~clk;

  ap_host_ctrl dut (
    .CLK100MHZ(clk), .rst(rst), .start(start), .n_cells(n_cells),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err(err),
    .ap_rst(ap_rst), .ap_mode(ap_mode), .ap_cmd(ap_cmd), .ap_sel_col(ap_sel_col),
    .ap_sel_internal_col(ap_sel_internal_col), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
    .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_rdata(ap_rdata), .ap_irq(ap_irq)
  );

  // AP model: columns A/B written by strobes, C = A|B computed when the pass completes.
  logic [WS-1:0] mem_a [0:(1<<AW)-1];
  logic [WS-1:0] mem_b [0:(1<<AW)-1];
  logic [WS-1:0] mem_c [0:(1<<AW)-1];
  int            mode_run = 0;
  int            irq_dly  = 3;
  logic          irq_en   = 1'b1;
  logic [AW-1:0] wr_addr [$];
  logic [1:0]    wr_sel  [$];
  logic [WS-1:0] wr_data [$];

  assign ap_irq = irq_en && ap_mode && (mode_run >= irq_dly);

  initial ap_rdata = '0;

  always @(posedge clk) begin
    if (ap_rst) begin
      for (int i = 0; i < (1<<AW); i++) begin
        mem_a[i] = '0; mem_b[i] = '0; mem_c[i] = '0;
      end
    end
    if (ap_write_en) begin
      if (ap_sel_col == 2'd0) mem_a[ap_addr] = ap_wdata;
      else if (ap_sel_col == 2'd1) mem_b[ap_addr] = ap_wdata;
      wr_addr.push_back(ap_addr);
      wr_sel.push_back(ap_sel_col);
      wr_data.push_back(ap_wdata);
    end
    if (ap_mode && ap_irq) begin
      for (int i = 0; i < (1<<AW); i++) mem_c[i] = mem_a[i] | mem_b[i];
    end
    if (ap_read_en) ap_rdata <= mem_c[ap_addr];
    mode_run <= ap_mode ? mode_run + 1 : 0;
  end

  int n_done = 0, n_reads = 0, n_mode = 0, n_strobe = 0, n_viol = 0;
  always @(negedge clk) begin
    if (done) n_done++;
    if (ap_read_en) n_reads++;
    if (ap_mode) n_mode++;
    if (ap_write_en || ap_read_en || ap_rst || ap_mode) n_strobe++;
    if (!ap_write_en && !ap_read_en && (ap_sel_col != 2'd0 || ap_addr != '0 || ap_wdata != '0)) n_viol++;
    if (ap_cmd != 3'b000 || ap_sel_internal_col || (ap_write_en && ap_read_en)) n_viol++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [WS-1:0] op_a [0:15];
  logic [WS-1:0] op_b [0:15];

  task automatic kick(input logic [AW:0] n);
    start = 1'b1; n_cells = n;
    @(negedge clk);
    start = 1'b0; n_cells = '0;
  endtask

  task automatic load(input int n, input int gap);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gap != 0 && (i % 2) == 1) repeat (gap) @(negedge clk);
      opnd_valid = 1'b1; opnd_a = op_a[i]; opnd_b = op_b[i];
      w = 0;
      while (!opnd_ready && w < 100) begin @(negedge clk); w++; end
      if (!opnd_ready) check("load_timeout", 0, 1);
      @(negedge clk);
      opnd_valid = 1'b0;
    end
  endtask

  task automatic collect(input int n, input bit stall);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!res_valid && w < 100) begin @(negedge clk); w++; end
      check($sformatf("res_valid[%0d]", i), res_valid, 1);
      check($sformatf("res_data[%0d]", i), res_data, op_a[i] | op_b[i]);
      if (stall && (i % 2) == 1) begin
        repeat (3) @(negedge clk);
        check($sformatf("res_hold[%0d]", i), res_data, op_a[i] | op_b[i]);
        check($sformatf("res_valid_hold[%0d]", i), res_valid, 1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 200) begin @(negedge clk); w++; end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_writes(input int n);
    check("write_count", wr_addr.size(), 2 * n);
    for (int i = 0; i < wr_addr.size() && i < 2 * n; i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_addr[i], i / 2);
      check($sformatf("wr_sel[%0d]", i), wr_sel[i], i % 2);
      check($sformatf("wr_data[%0d]", i), wr_data[i], (i % 2) ? op_b[i/2] : op_a[i/2]);
    end
  endtask

  int d0, r0, m0, s0;

  initial begin
    rst = 1'b1; start = 1'b0; n_cells = '0; opnd_valid = 1'b0;
    opnd_a = '0; opnd_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_opnd_ready", opnd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ap_mode", ap_mode, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single cell
    op_a[0] = 8'h0F; op_b[0] = 8'hF0;
    wr_addr.delete(); wr_sel.delete(); wr_data.delete();
    d0 = n_done; r0 = n_reads;
    kick(1);
    check("single_busy", busy, 1);
    load(1, 0);
    collect(1, 0);
    wait_done();
    check("single_err", err, 0);
    check("single_reads", n_reads - r0, 1);
    check("single_dones", n_done - d0, 1);
    check_writes(1);

    // Backpressure, n=4
    op_a[0] = 8'h01; op_b[0] = 8'h10;
    op_a[1] = 8'h22; op_b[1] = 8'h04;
    op_a[2] = 8'h80; op_b[2] = 8'h08;
    op_a[3] = 8'h3C; op_b[3] = 8'hC3;
    wr_addr.delete(); wr_sel.delete(); wr_data.delete();
    d0 = n_done; r0 = n_reads;
    kick(4);
    load(4, 2);
    collect(4, 1);
    wait_done();
    check("bp_err", err, 0);
    check("bp_reads", n_reads - r0, 4);
    check("bp_dones", n_done - d0, 1);
    check_writes(4);

    // Empty and oversize jobs
    s0 = n_strobe;
    kick(0);
    check("empty_done", done, 1);
    check("empty_err", err, 1);
    check("empty_busy", busy, 0);
    @(negedge clk);
    check("empty_done_low", done, 0);
    kick(11'd513);
    check("over_done", done, 1);
    check("over_err", err, 1);
    check("over_busy", busy, 0);
    @(negedge clk);
    check("empty_no_strobes", n_strobe - s0, 0);

    // Timeout
    irq_en = 1'b0;
    op_a[0] = 8'h55; op_b[0] = 8'hAA;
    d0 = n_done; r0 = n_reads; m0 = n_mode;
    kick(1);
    check("tmo_err_cleared", err, 0);
    load(1, 0);
    wait_done();
    check("tmo_mode_cycles", n_mode - m0, 64);
    check("tmo_err", err, 1);
    check("tmo_reads", n_reads - r0, 0);
    check("tmo_dones", n_done - d0, 1);
    irq_en = 1'b1;

    // Reset in the middle of loading
    for (int i = 0; i < 8; i++) begin op_a[i] = 8'(i); op_b[i] = 8'(8'h10 << (i % 4)); end
    d0 = n_done;
    kick(8);
    load(2, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", opnd_ready, 0);
    check("mid_rst_wr", ap_write_en, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_no_done", n_done - d0, 0);
    op_a[0] = 8'h12; op_b[0] = 8'h21;
    op_a[1] = 8'h40; op_b[1] = 8'h04;
    wr_addr.delete(); wr_sel.delete(); wr_data.delete();
    r0 = n_reads;
    kick(2);
    load(2, 0);
    collect(2, 0);
    wait_done();
    check("post_rst_reads", n_reads - r0, 2);
    check("post_rst_dones", n_done - d0, 1);
    check_writes(2);

    // start while busy
    irq_dly = 10;
    op_a[0] = 8'h0A; op_b[0] = 8'h50;
    d0 = n_done; r0 = n_reads;
    kick(1);
    load(1, 0);
    begin
      int w;
      w = 0;
      while (!ap_mode && w < 100) begin @(negedge clk); w++; end
      check("busy_in_run", ap_mode, 1);
    end
    kick(3);
    collect(1, 0);
    wait_done();
    repeat (5) @(negedge clk);
    check("busy_idle_after", busy, 0);
    check("busy_reads", n_reads - r0, 1);
    check("busy_dones", n_done - d0, 1);

    check("idle_bus_violations", n_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ap_host_ctrl.md
AP_HOST_CTRL -- requirements
Module: ap_host_ctrl

Interface
REQ-001 Parameters SHALL be:
- WORD_SIZE, 8, operand/result width.
- CELL_QUANT, 512, AP cell count.
- ADDR_W, 10, AP address width, equal to ceil(log2(CELL_QUANT))+1.
- RD_LAT, 2, cycles from ap_read_en to valid ap_rdata.
- TIMEOUT, 64, maximum cycles ap_mode stays high waiting for ap_irq.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK100MHZ, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, job request pulse.
- n_cells, in, ADDR_W+1, cell count, sampled at start.
- opnd_valid, in, 1, operand pair valid.
- opnd_ready, out, 1, operand pair accepted.
- opnd_a, in, WORD_SIZE, column A operand.
- opnd_b, in, WORD_SIZE, column B operand.
- res_valid, out, 1, result valid.
- res_ready, in, 1, result accepted.
- res_data, out, WORD_SIZE, column C result.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job-end pulse.
- err, out, 1, sticky error, cleared by the next accepted start.
- ap_rst, out, 1, AP reset.
- ap_mode, out, 1, AP compute enable.
- ap_cmd, out, 3, AP command, constant 3'b000 (OR).
- ap_sel_col, out, 2, column select.
- ap_sel_internal_col, out, 1, constant 0.
- ap_addr, out, ADDR_W, AP cell address.
- ap_wdata, out, WORD_SIZE, AP write data.
- ap_write_en, out, 1, AP write strobe.
- ap_read_en, out, 1, AP read strobe.
- ap_rdata, in, WORD_SIZE, AP data_out.
- ap_irq, in, 1, AP completion (ap_state_irq).

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, LOAD_A, LOAD_B, RUN, RD_ISSUE, RD_WAIT, RD_OUT, FIN.

REQ-004 IDLE:
- start=1 and n_cells in 1..CELL_QUANT: latch n_cells, clear err, enter CLEAR.
- start=1 and n_cells=0, or n_cells>CELL_QUANT: set err, pulse done next cycle, stay IDLE.
- No AP activity in either case.

REQ-005 start SHALL be ignored whenever busy=1.

REQ-006 CLEAR: ap_rst=1 for exactly one cycle, cnt<=0, then LOAD_A.

REQ-007 LOAD_A:
- opnd_ready=1.
- On opnd_valid&&opnd_ready: same cycle drive ap_write_en=1, ap_sel_col=0, ap_addr=cnt, ap_wdata=opnd_a; register opnd_b; go LOAD_B.

REQ-008 LOAD_B:
- opnd_ready=0; drive ap_write_en=1, ap_sel_col=1, ap_addr=cnt, ap_wdata=latched b.
- If cnt==n-1: go RUN with cnt<=0; else cnt<=cnt+1 and go LOAD_A.

REQ-009 ap_write_en SHALL be 0 in every state except the LOAD_A handshake cycle and LOAD_B.

REQ-010 RUN:
- ap_mode=1 continuously; a timer counts cycles from RUN entry.
- ap_irq=1: next cycle ap_mode=0, go RD_ISSUE.
- Timer reaches TIMEOUT with no ap_irq: ap_mode=0, set err, go FIN; no reads issued.

REQ-011 RD_ISSUE: one cycle with ap_read_en=1, ap_sel_col=2, ap_addr=cnt, then RD_WAIT.

REQ-012 RD_WAIT: wait RD_LAT-1 further cycles, capture ap_rdata into res_data, go RD_OUT.

REQ-013 RD_OUT:
- res_valid=1; res_data SHALL hold stable until res_valid&&res_ready.
- On that handshake: if cnt==n-1 go FIN, else cnt<=cnt+1 and go RD_ISSUE.

REQ-014 Results SHALL emerge in ascending address order 0..n-1, exactly n per successful job.

REQ-015 FIN: done=1 for one cycle, go IDLE.

REQ-016 busy SHALL be 1 in every state except IDLE.

REQ-017 ap_sel_col SHALL be 0 whenever no read or write strobe is active.

REQ-018 ap_addr and ap_wdata SHALL be 0 whenever no read or write strobe is active.

REQ-019 All counters SHALL be ADDR_W+1 bits wide; no wrap occurs for n_cells=CELL_QUANT.

Reset
REQ-020 While rst=1, asynchronously and regardless of state:
- FSM<=IDLE; all counters and timer 0.
- busy=0, done=0, err=0, opnd_ready=0, res_valid=0, res_data=0.
- ap_mode=0, ap_write_en=0, ap_read_en=0, ap_rst=0.

REQ-021 Reset mid-job SHALL abandon the job without emitting done; the next start SHALL run a complete job.

Verification
REQ-022 Single cell: n=1, a=0x0F, b=0xF0, AP model ORs -> writes A@0=0x0F then B@0=0xF0, one read of C@0, res_data=0xFF, done pulse, err=0.

REQ-023 Backpressure: n=4, opnd_valid gaps and res_ready toggling -> 8 writes at addresses 0,0,1,1,2,2,3,3; results for addresses 0..3 in order; res_data stable while stalled.

REQ-024 Empty job: start with n_cells=0 -> done one cycle later, err=1, busy stays 0, no ap_* strobes.

REQ-025 Timeout: ap_irq held 0 -> ap_mode high for exactly 64 cycles, then err=1, done pulse, zero ap_read_en pulses.

REQ-026 Reset mid-LOAD: rst during cnt=2 of n=8 -> all outputs reset immediately; a following n=2 job completes with correct results.

REQ-027 start while busy: second start mid-RUN -> ignored; exactly one done pulse.
